// File: rtl/hist_pkg.sv
// Shared definitions for the histogram command scheduler: default sizes,
// engine command opcodes and the scheduler state encoding.
package hist_pkg;

    localparam int RATE_BIT_DEF  = 3;
    localparam int RATE_CLIP_DEF = 4;
    localparam int HISTOSIZE_DEF = 16;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_REPORT = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after last_grant+1, wrapping.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last_grant,
    output logic           grant_valid,
    output logic [CHW-1:0] grant_idx
);

    int             jn;
    logic [CHW-1:0] j;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        jn          = 0;
        j           = '0;
        for (int i = 1; i <= NCH; i++) begin
            jn = int'(last_grant) + i;
            if (jn >= NCH) jn = jn - NCH;
            j = CHW'(jn);
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = j;
            end
        end
    end

endmodule

// File: rtl/hist_sched.sv
// Schedules per-channel "bin finished" samples onto one shared histogram
// engine, reporting and clearing a channel's histogram every HISTOSIZE samples.
module hist_sched
    import hist_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int RATE_BIT  = RATE_BIT_DEF,
    parameter int RATE_CLIP = RATE_CLIP_DEF,
    parameter int HISTOSIZE = HISTOSIZE_DEF,
    localparam int CHW      = idx_w(NCH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*RATE_BIT-1:0] rate,
    output logic [NCH-1:0]          ack,
    output logic                    cmd_valid,
    output logic                    cmd_op,
    output logic [CHW-1:0]          cmd_ch,
    output logic [RATE_BIT-1:0]     cmd_rate,
    input  logic                    cmd_ready,
    output logic                    win_valid,
    output logic [CHW-1:0]          win_ch,
    input  logic                    win_ready,
    output logic                    busy
);

    localparam int CW = idx_w(HISTOSIZE);

    state_t                       state;
    logic [CHW-1:0]               ch;
    logic [CHW-1:0]               last_grant;
    logic [NCH-1:0][CW-1:0]       win_cnt;
    logic [NCH-1:0][RATE_BIT-1:0] clipped;
    logic                         grant_valid;
    logic [CHW-1:0]               grant_idx;
    logic                         last_sample;

    for (genvar k = 0; k < NCH; k++) begin : g_clip
        logic [RATE_BIT-1:0] r;
        assign r          = rate[k*RATE_BIT +: RATE_BIT];
        assign clipped[k] = (int'(r) > RATE_CLIP) ? RATE_BIT'(RATE_CLIP) : r;
    end

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign last_sample = (win_cnt[ch] == CW'(HISTOSIZE - 1));

    // Command fields are zeroed whenever their valid drops so idle outputs are clean.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            ch         <= '0;
            last_grant <= CHW'(NCH - 1);
            win_cnt    <= '0;
            ack        <= '0;
            cmd_valid  <= 1'b0;
            cmd_op     <= OP_ADD;
            cmd_ch     <= '0;
            cmd_rate   <= '0;
            win_valid  <= 1'b0;
            win_ch     <= '0;
            busy       <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state      <= ST_ADD;
                        busy       <= 1'b1;
                        ch         <= grant_idx;
                        last_grant <= grant_idx;
                        ack        <= NCH'(1) << grant_idx;
                        cmd_valid  <= 1'b1;
                        cmd_op     <= OP_ADD;
                        cmd_ch     <= grant_idx;
                        cmd_rate   <= clipped[grant_idx];
                    end
                end
                ST_ADD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_ch    <= '0;
                        cmd_rate  <= '0;
                        if (last_sample) begin
                            win_cnt[ch] <= '0;
                            state       <= ST_REPORT;
                            win_valid   <= 1'b1;
                            win_ch      <= ch;
                        end else begin
                            win_cnt[ch] <= win_cnt[ch] + 1'b1;
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                        end
                    end
                end
                ST_REPORT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        win_ch    <= '0;
                        state     <= ST_CLEAR;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_CLEAR;
                        cmd_ch    <= ch;
                        cmd_rate  <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_op    <= OP_ADD;
                        cmd_ch    <= '0;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_sched.sv
// Bench for hist_sched: directed scenarios plus random traffic, all compared
// each cycle against a transaction-level model of the scheduler's rules.
module tb_hist_sched;

    localparam int NCH  = 4;
    localparam int RB   = 3;
    localparam int CLIP = 4;
    localparam int HS   = 16;

    localparam int S_IDLE = 0, S_ADD = 1, S_REP = 2, S_CLR = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH*RB-1:0] rate = '0;
    logic [NCH-1:0]    ack;
    logic              cmd_valid, cmd_op;
    logic [1:0]        cmd_ch;
    logic [RB-1:0]     cmd_rate;
    logic              cmd_ready = 1'b0;
    logic              win_valid;
    logic [1:0]        win_ch;
    logic              win_ready = 1'b0;
    logic              busy;

    hist_sched #(.NCH(NCH), .RATE_BIT(RB), .RATE_CLIP(CLIP), .HISTOSIZE(HS)) dut (
        .CLK(CLK), .RST(RST), .req(req), .rate(rate), .ack(ack),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_rate(cmd_rate),
        .cmd_ready(cmd_ready), .win_valid(win_valid), .win_ch(win_ch),
        .win_ready(win_ready), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int             ntests = 0;
    int             nfail  = 0;
    int             m_st, m_ch, m_rate, m_last;
    int             m_cnt [NCH];
    logic [NCH-1:0] e_ack;
    int             grants[$];

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic int rate_of(int c);
        logic [RB-1:0] r;
        r = rate[c*RB +: RB];
        return int'(r);
    endfunction

    function automatic void model_reset();
        m_st   = S_IDLE;
        m_ch   = 0;
        m_rate = 0;
        m_last = NCH - 1;
        e_ack  = '0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endfunction

    // One clock of the scheduler's rules, using the inputs present at the edge.
    function automatic void model_step();
        e_ack = '0;
        case (m_st)
            S_IDLE: begin
                for (int i = 1; i <= NCH; i++) begin
                    int c;
                    c = (m_last + i) % NCH;
                    if (req[c]) begin
                        m_ch     = c;
                        m_rate   = (rate_of(c) > CLIP) ? CLIP : rate_of(c);
                        m_last   = c;
                        e_ack[c] = 1'b1;
                        grants.push_back(c);
                        m_st     = S_ADD;
                        break;
                    end
                end
            end
            S_ADD: if (cmd_ready) begin
                m_cnt[m_ch] = m_cnt[m_ch] + 1;
                if (m_cnt[m_ch] == HS) begin
                    m_cnt[m_ch] = 0;
                    m_st        = S_REP;
                end else begin
                    m_st = S_IDLE;
                end
            end
            S_REP: if (win_ready) m_st = S_CLR;
            S_CLR: if (cmd_ready) m_st = S_IDLE;
            default: m_st = S_IDLE;
        endcase
    endfunction

    function automatic void compare();
        logic cv;
        cv = (m_st == S_ADD) || (m_st == S_CLR);
        chk("ack", ack, e_ack);
        chk("cmd_valid", cmd_valid, cv);
        chk("cmd_op", cmd_op, m_st == S_CLR);
        chk("cmd_ch", cmd_ch, cv ? m_ch : 0);
        chk("cmd_rate", cmd_rate, (m_st == S_ADD) ? m_rate : 0);
        chk("win_valid", win_valid, m_st == S_REP);
        chk("win_ch", win_ch, (m_st == S_REP) ? m_ch : 0);
        chk("busy", busy, m_st != S_IDLE);
        chk("excl_valid", cmd_valid & win_valid, 0);
    endfunction

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic tick();
        @(posedge CLK);
        if (RST) model_step();
        @(negedge CLK);
        compare();
        req = req & ~e_ack;
    endtask

    task automatic set_rate(int c, int v);
        rate[c*RB +: RB] = RB'(v);
    endtask

    task automatic zero_lits(string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_cv"}, cmd_valid, 0);
        chk({tag, "_op"}, cmd_op, 0);
        chk({tag, "_ch"}, cmd_ch, 0);
        chk({tag, "_rate"}, cmd_rate, 0);
        chk({tag, "_wv"}, win_valid, 0);
        chk({tag, "_wch"}, win_ch, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req = '0;
        #1;
        model_reset();
        compare();
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100; i++) begin
            if (req == '0 && m_st == S_IDLE) break;
            tick();
        end
        chk("drain_done", (req == '0 && m_st == S_IDLE), 1);
    endtask

    initial begin
        int wv;
        model_reset();
        @(negedge CLK);
        compare();
        zero_lits("rst");
        tick();
        RST = 1'b1;
        tick();

        // single sample on ch0
        set_rate(0, 3);
        cmd_ready = 1'b1;
        req = 4'b0001;
        tick();
        chk("s1_ack", ack, 4'b0001);
        chk("s1_cv", cmd_valid, 1);
        chk("s1_ch", cmd_ch, 0);
        chk("s1_rate", cmd_rate, 3);
        tick();
        chk("s1_idle_cv", cmd_valid, 0);
        chk("s1_idle_busy", busy, 0);

        // round-robin order from reset
        do_reset();
        grants.delete();
        req = 4'b1111;
        drain();
        req = 4'b0001;
        drain();
        chk("rr_n", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk("rr_order", grants[i], i % 4);

        // clipping
        set_rate(2, 7);
        req = 4'b0100;
        tick();
        chk("clip_ch", cmd_ch, 2);
        chk("clip_rate", cmd_rate, 4);
        drain();

        // engine stall: fields stable, new requests wait
        grants.delete();
        set_rate(0, 5);
        cmd_ready = 1'b0;
        req = 4'b0001;
        tick();
        chk("st_ack", ack, 4'b0001);
        req = 4'b1110;
        set_rate(0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_ack0", ack, 0);
            chk("st_ch", cmd_ch, 0);
            chk("st_rate", cmd_rate, 4);
            chk("st_cv", cmd_valid, 1);
        end
        cmd_ready = 1'b1;
        drain();
        chk("st_n", grants.size(), 4);
        if (grants.size() >= 2) chk("st_next", grants[1], 1);

        // window on ch1 with delayed win_ready
        do_reset();
        win_ready = 1'b0;
        req = 4'b0001;
        drain();
        for (int i = 0; i < HS; i++) begin
            req = 4'b0010;
            tick();
            tick();
        end
        chk("win_v", win_valid, 1);
        chk("win_ch", win_ch, 1);
        wv = 1;
        for (int i = 0; i < 20; i++) begin
            win_ready = (wv >= 5);
            tick();
            if (win_valid) wv++;
            else break;
        end
        chk("win_hold", wv, 5);
        chk("clr_cv", cmd_valid, 1);
        chk("clr_op", cmd_op, 1);
        chk("clr_ch", cmd_ch, 1);
        chk("clr_rate", cmd_rate, 0);
        win_ready = 1'b0;
        tick();
        chk("clr_done", busy, 0);
        chk("cnt1", m_cnt[1], 0);
        chk("cnt0", m_cnt[0], 1);
        // ch0 had one sample already, so its window closes 15 samples later
        for (int i = 0; i < HS - 1; i++) begin
            req = 4'b0001;
            tick();
            tick();
            chk("ch0_win", win_valid, i == HS - 2);
        end
        win_ready = 1'b1;
        drain();

        // reset during REPORT
        win_ready = 1'b0;
        for (int i = 0; i < HS; i++) begin
            req = 4'b1000;
            tick();
            tick();
        end
        chk("pre_rst_wv", win_valid, 1);
        chk("pre_rst_wch", win_ch, 3);
        RST = 1'b0;
        #1;
        model_reset();
        zero_lits("arst");
        compare();
        tick();
        RST = 1'b1;
        set_rate(0, 3);
        req = 4'b0001;
        tick();
        chk("post_ack", ack, 4'b0001);
        chk("post_rate", cmd_rate, 3);
        tick();
        chk("post_cnt0", m_cnt[0], 1);
        chk("post_cnt3", m_cnt[3], 0);

        // random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < NCH; k++)
                if (!req[k] && $urandom_range(3) == 0) req[k] = 1'b1;
            rate      = (NCH*RB)'($urandom);
            cmd_ready = ($urandom_range(2) != 0);
            win_ready = ($urandom_range(1) != 0);
            if (cyc == 2000) begin
                RST = 1'b0;
                #1;
                model_reset();
                compare();
                tick();
                RST = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
